pipe_skid_stage: RTL and testbench

- Parametrised pipeline stage register for the RISC-V pipeline; successor to the fixed MEM/WB flop bank.
- Adds valid/ready handshake with a 2-entry skid buffer (stall without a combinational ready path), synchronous flush (bubble insertion) and a saturating stall-cycle counter.
- Instantiated between any two stages (IF/ID … MEM/WB) with channel count and widths set per stage.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_payload_reg.sv | 28 ++
 rtl/pipe_skid_stage.sv | 131 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register slice.
//   pipe_state_e : occupancy of a skid stage (EMPTY, FULL, SKID)
//   XLEN         : default data channel width
//   REG_IDX_W    : default destination register index width
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // main invalid
        FULL  = 2'd1,   // main valid, skid invalid
        SKID  = 2'd2    // main and skid both valid
    } pipe_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register holding one {ctrl, rd, data} entry.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : load d on the rising edge
//   d / q      : packed payload in / registered payload out
module pipe_payload_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] payload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
        end else if (en) begin
            payload_q <= d;
        end
    end

    assign q = payload_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : drop every held entry (bubble insertion)
//   in_valid / in_ready  : upstream handshake; in_ready is registered
//   in_ctrl/in_rd/in_data: upstream entry
//   out_valid/out_ready  : downstream handshake; out_valid is registered
//   out_ctrl/out_rd/out_data : entry held in the main register
//                          (out_ctrl forced to 0 while out_valid=0)
//   stall_cnt            : saturating count of out_valid & !out_ready cycles
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned NUM_DATA   = 4,
    parameter int unsigned CTRL_WIDTH = 4,
    parameter int unsigned RD_WIDTH   = REG_IDX_W,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CTRL_WIDTH-1:0]               in_ctrl,
    input  logic [RD_WIDTH-1:0]                 in_rd,
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CTRL_WIDTH-1:0]               out_ctrl,
    output logic [RD_WIDTH-1:0]                 out_rd,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]                stall_cnt
);

    localparam int unsigned PW = CTRL_WIDTH + RD_WIDTH + NUM_DATA * DATA_WIDTH;

    pipe_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]         in_pl, main_pl_d, main_pl_q, skid_pl_q;
    logic                  main_en, skid_en, main_from_skid;
    logic [CTRL_WIDTH-1:0] main_ctrl;

    assign in_pl = {in_ctrl, in_rd, in_data};

    // Both handshake outputs are pure decodes of the state flop, so there
    // is no combinational path from out_ready to in_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != SKID);

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            // Payload regs keep their contents; only occupancy is dropped.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_en = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready && in_valid) begin
                        main_en = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end else if (in_valid) begin
                        skid_en = 1'b1;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_pl_d = main_from_skid ? skid_pl_q : in_pl;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_payload_reg #(.WIDTH(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_pl_d),
        .q     (main_pl_q)
    );

    pipe_payload_reg #(.WIDTH(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_pl),
        .q     (skid_pl_q)
    );

    assign {main_ctrl, out_rd, out_data} = main_pl_q;
    // Bubbles must never assert write enables downstream.
    assign out_ctrl  = main_ctrl & {CTRL_WIDTH{out_valid}};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: scoreboard of accepted entries,
// popped and compared on each downstream handshake.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned ND = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 5;
    localparam int unsigned NW = 4;

    typedef struct packed {
        logic [CW-1:0]         ctrl;
        logic [RW-1:0]         rd;
        logic [ND-1:0][DW-1:0] data;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [CW-1:0]         in_ctrl;
    logic [RW-1:0]         in_rd;
    logic [ND-1:0][DW-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         out_ctrl;
    logic [RW-1:0]         out_rd;
    logic [ND-1:0][DW-1:0] out_data;
    logic [NW-1:0]         stall_cnt;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;

    pipe_skid_stage #(
        .DATA_WIDTH (DW),
        .NUM_DATA   (ND),
        .CTRL_WIDTH (CW),
        .RD_WIDTH   (RW),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [7:0] v);
        entry_t e;
        e.ctrl = v[3:0] | 4'h1;
        e.rd   = v[4:0];
        for (int k = 0; k < int'(ND); k++) begin
            e.data[k] = {24'h0, v} + 32'h1000 * k;
        end
        return e;
    endfunction

    task automatic set_in(input logic v, input entry_t e);
        in_valid = v;
        in_ctrl  = e.ctrl;
        in_rd    = e.rd;
        in_data  = e.data;
    endtask

    // Called at a falling edge with inputs already driven: updates the
    // scoreboard for the coming rising edge, then advances one cycle.
    task automatic step();
        entry_t exp;
        entry_t act;
        if (!out_valid) begin
            checks++;
            if (out_ctrl !== '0) begin
                errors++;
                $display("FAIL bubble_ctrl got %h want 0", out_ctrl);
            end
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                act = {out_ctrl, out_rd, out_data};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got %h want none", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL deliver got %h want %h", act, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_ctrl, in_rd, in_data});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, mk(8'h00));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, mk(8'h33));
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_ctrl, in_ready, stall_cnt} !== {1'b0, 4'h0, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL reset_ctl got v=%b c=%h r=%b s=%h want v=0 c=0 r=1 s=0",
                     out_valid, out_ctrl, in_ready, stall_cnt);
        end
        checks++;
        if ({out_rd, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_payload got %h want 0", {out_rd, out_data});
        end
        rst_n = 1'b1;
        set_in(1'b1, mk(8'h55));
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_latency got out_valid=%b want 1", out_valid);
        end
        set_in(1'b0, mk(8'h00));
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, mk(8'(8'h10 + i)));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid);
                end
            end
            step();
        end
        set_in(1'b0, mk(8'h00));
        step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain got left=%0d v=%b want left=0 v=0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, mk(8'hA0));
        step();
        set_in(1'b1, mk(8'hB0));
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_b got %b want 1", in_ready);
        end
        step();
        set_in(1'b1, mk(8'hC0));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_c got %b want 0", in_ready);
        end
        checks++;
        if (out_data[0] !== 32'h0000_00A0) begin
            errors++;
            $display("FAIL bp_hold_a got %h want 000000a0", out_data[0]);
        end
        step();
        step();
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after got %b want 1", in_ready);
        end
        step();
        set_in(1'b0, mk(8'h00));
        step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got left=%0d v=%b want left=0 v=0",
                     sb.size(), out_valid);
        end
        checks++;
        if (stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt);
        end
    endtask

    task automatic test_flush();
        entry_t junk;
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, mk(8'hA0));
        step();
        set_in(1'b1, mk(8'hB0));
        step();
        junk      = mk(8'hEE);
        junk.ctrl = 4'hF;
        flush     = 1'b1;
        set_in(1'b1, junk);
        step();
        flush = 1'b0;
        set_in(1'b0, mk(8'h00));
        checks++;
        if ({out_valid, out_ctrl, in_ready} !== {1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL flush_skid got v=%b c=%h r=%b want v=0 c=0 r=1",
                     out_valid, out_ctrl, in_ready);
        end
        checks++;
        if (stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL flush_keeps_cnt got %0d want 2", stall_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_ghost[%0d] got %b want 0", i, out_valid);
            end
            step();
        end
        // Flush from FULL while a new entry would otherwise be accepted.
        out_ready = 1'b0;
        set_in(1'b1, mk(8'h61));
        step();
        flush = 1'b1;
        set_in(1'b1, mk(8'h62));
        step();
        flush = 1'b0;
        set_in(1'b0, mk(8'h00));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_discard got %b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        int exp;
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, mk(8'h70));
        step();
        set_in(1'b0, mk(8'h00));
        for (int n = 1; n <= 20; n++) begin
            step();
            exp = (n > 15) ? 15 : n;
            checks++;
            if (stall_cnt !== 4'(exp)) begin
                errors++;
                $display("FAIL sat_cnt[%0d] got %0d want %0d", n, stall_cnt, exp);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_after_flush got %0d want 15", stall_cnt);
        end
        apply_reset();
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_after_reset got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, mk(8'h81));
        step();
        set_in(1'b1, mk(8'h82));
        step();
        set_in(1'b0, mk(8'h00));
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL async_pre got v=%b r=%b want v=1 r=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, in_ready, stall_cnt} !== {1'b0, 4'h0, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL async_ctl got v=%b c=%h r=%b s=%h want v=0 c=0 r=1 s=0",
                     out_valid, out_ctrl, in_ready, stall_cnt);
        end
        checks++;
        if ({out_rd, out_data} !== '0) begin
            errors++;
            $display("FAIL async_payload got %h want 0", {out_rd, out_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, mk(8'h00));
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
